// File: rtl/fft_pkg.sv
// Shared definitions for the in-place radix-2 DIF FFT stage controllers:
// one-hot state encoding and the address helper functions.
package fft_pkg;

    // Widest address any controller in this family generates.
    localparam int FFT_MAX_W = 16;
    localparam logic [FFT_MAX_W-1:0] FFT_ONE  = 16'd1;
    localparam logic [FFT_MAX_W-1:0] FFT_ZERO = 16'd0;

    // One-hot controller states.
    localparam logic [4:0] ST_IDLE   = 5'b00001;
    localparam logic [4:0] ST_RD_TOP = 5'b00010;
    localparam logic [4:0] ST_RD_BOT = 5'b00100;
    localparam logic [4:0] ST_DRAIN  = 5'b01000;
    localparam logic [4:0] ST_DONE   = 5'b10000;

    // Reverse the low 'size' bits of addr; bits above 'size' come back as 0.
    function automatic logic [FFT_MAX_W-1:0] bitrev(input logic [FFT_MAX_W-1:0] addr,
                                                    input int size);
        logic [FFT_MAX_W-1:0] r;
        r = FFT_ZERO;
        for (int i = 0; i < FFT_MAX_W; i++) begin
            if (i < size) begin
                r = (r << 1) | ((addr >> i) & FFT_ONE);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Open a 0 bit at position pos: bits below pos stay, bits at/above move up one.
    function automatic logic [FFT_MAX_W-1:0] insert_zero(input logic [FFT_MAX_W-1:0] b,
                                                         input int pos);
        logic [FFT_MAX_W-1:0] lo_mask;
        lo_mask = (FFT_ONE << pos) - FFT_ONE;
        return ((b & ~lo_mask) << 1) | (b & lo_mask);
    endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// LAT-deep delay line for a (valid, address) pair. Used to turn the read
// stream into the write-back stream after the butterfly latency.
module fft_addr_delay #(
    parameter int LAT  = 3,
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vld_i,
    input  logic [SIZE-1:0] addr_i,
    output logic            vld_o,
    output logic [SIZE-1:0] addr_o
);

    logic [LAT-1:0]  vld_sr_r;
    logic [SIZE-1:0] addr_sr_r [LAT];

    // Shift valid and address one stage per cycle; reset empties the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr_r <= {LAT{1'b0}};
            for (int i = 0; i < LAT; i++) begin
                addr_sr_r[i] <= {SIZE{1'b0}};
            end
        end else begin
            vld_sr_r[0]  <= vld_i;
            addr_sr_r[0] <= addr_i;
            for (int i = 1; i < LAT; i++) begin
                vld_sr_r[i]  <= vld_sr_r[i-1];
                addr_sr_r[i] <= addr_sr_r[i-1];
            end
        end
    end

    assign vld_o  = vld_sr_r[LAT-1];
    assign addr_o = addr_sr_r[LAT-1];

endmodule

// File: rtl/fft_stage_addr_ctrl.sv
// Read / twiddle / write-back address sequencer for one radix-2 DIF stage of
// an N-point in-place FFT. The stage index is chosen per pass; write-back
// addresses trail the reads by LAT cycles and may be bit-reversed.
module fft_stage_addr_ctrl
    import fft_pkg::*;
#(
    parameter int N    = 16,
    parameter int SIZE = 4,
    parameter int LAT  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] stage_i,
    input  logic            brev_i,
    output logic            busy,
    output logic            done_o,
    output logic            err_o,
    output logic            en_rd,
    output logic [SIZE-1:0] rd_ptr,
    output logic            en_rd_tw,
    output logic [SIZE-2:0] tw_ptr,
    output logic            en_wr,
    output logic [SIZE-1:0] wr_ptr
);

    localparam int BW = SIZE - 1;
    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [BW-1:0]   B_ZERO = BW'(0);
    localparam logic [BW-1:0]   B_ONE  = BW'(1);
    localparam logic [BW-1:0]   B_LAST = BW'(N / 2 - 1);
    localparam logic [DW-1:0]   D_ZERO = DW'(0);
    localparam logic [DW-1:0]   D_ONE  = DW'(1);
    localparam logic [DW-1:0]   D_LAST = DW'(LAT - 1);
    localparam logic [SIZE:0]   SIZE_V = (SIZE + 1)'(SIZE);
    localparam logic [SIZE-1:0] A_ZERO = SIZE'(0);
    localparam logic [BW-1:0]   T_ZERO = BW'(0);

    // Controller state and pass context.
    logic [4:0]      state_r, state_s;
    logic [BW-1:0]   b_r, b_s;
    logic [DW-1:0]   drain_r, drain_s;
    logic [SIZE-1:0] stage_r, stage_s;
    logic            brev_r, brev_s;

    // Next values of the registered outputs.
    logic            busy_s, done_s, err_s;
    logic            en_rd_s, en_rd_tw_s;
    logic [SIZE-1:0] rd_ptr_s;
    logic [SIZE-2:0] tw_ptr_s;

    // Butterfly address arithmetic, carried out at the package width.
    int                   pos_s;
    logic [FFT_MAX_W-1:0] b_ext_s, top_ext_s, h_ext_s, bot_ext_s, tw_ext_s, rev_ext_s;
    logic [SIZE-1:0]      top_s, bot_s, dly_addr_s;
    logic [SIZE-2:0]      tw_s;
    logic                 addr_unused_s;

    // Next-state logic: pass sequencing, butterfly counter and drain timer.
    always_comb begin
        state_s = state_r;
        b_s     = b_r;
        drain_s = drain_r;
        stage_s = stage_r;
        brev_s  = brev_r;
        err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if ({1'b0, stage_i} < SIZE_V) begin
                        state_s = ST_RD_TOP;
                        b_s     = B_ZERO;
                        stage_s = stage_i;
                        brev_s  = brev_i;
                    end else begin
                        err_s   = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD_TOP: begin
                state_s = ST_RD_BOT;
            end
            ST_RD_BOT: begin
                if (b_r == B_LAST) begin
                    state_s = ST_DRAIN;
                    drain_s = D_ZERO;
                end else begin
                    state_s = ST_RD_TOP;
                    b_s     = b_r + B_ONE;
                end
            end
            ST_DRAIN: begin
                // Leave once the last read has reached the end of the delay line.
                if (drain_r == D_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    drain_s = drain_r + D_ONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                b_s     = B_ZERO;
                drain_s = D_ZERO;
            end
        endcase
    end

    // Top/bottom/twiddle addresses of the butterfly selected for the next cycle.
    always_comb begin
        pos_s     = SIZE - 1 - int'(stage_s);
        b_ext_s   = FFT_MAX_W'(b_s);
        top_ext_s = insert_zero(b_ext_s, pos_s);
        h_ext_s   = FFT_ONE << pos_s;
        bot_ext_s = top_ext_s | h_ext_s;
        tw_ext_s  = (b_ext_s & (h_ext_s - FFT_ONE)) << stage_s;
    end

    assign top_s = top_ext_s[SIZE-1:0];
    assign bot_s = bot_ext_s[SIZE-1:0];
    assign tw_s  = tw_ext_s[SIZE-2:0];

    // Output decode from the state being entered, so outputs leave flops.
    always_comb begin
        busy_s     = 1'b0;
        done_s     = 1'b0;
        en_rd_s    = 1'b0;
        rd_ptr_s   = A_ZERO;
        en_rd_tw_s = 1'b0;
        tw_ptr_s   = T_ZERO;
        case (state_s)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_RD_TOP: begin
                busy_s     = 1'b1;
                en_rd_s    = 1'b1;
                rd_ptr_s   = top_s;
                en_rd_tw_s = 1'b1;
                tw_ptr_s   = tw_s;
            end
            ST_RD_BOT: begin
                busy_s   = 1'b1;
                en_rd_s  = 1'b1;
                rd_ptr_s = bot_s;
            end
            ST_DRAIN: begin
                busy_s = 1'b1;
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // State, pass context and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            b_r      <= B_ZERO;
            drain_r  <= D_ZERO;
            stage_r  <= A_ZERO;
            brev_r   <= 1'b0;
            busy     <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
            en_rd    <= 1'b0;
            rd_ptr   <= A_ZERO;
            en_rd_tw <= 1'b0;
            tw_ptr   <= T_ZERO;
        end else begin
            state_r  <= state_s;
            b_r      <= b_s;
            drain_r  <= drain_s;
            stage_r  <= stage_s;
            brev_r   <= brev_s;
            busy     <= busy_s;
            done_o   <= done_s;
            err_o    <= err_s;
            en_rd    <= en_rd_s;
            rd_ptr   <= rd_ptr_s;
            en_rd_tw <= en_rd_tw_s;
            tw_ptr   <= tw_ptr_s;
        end
    end

    // Write address as it enters the delay line: reversed when brev is latched.
    always_comb begin
        rev_ext_s = bitrev(FFT_MAX_W'(rd_ptr), SIZE);
        if (brev_r) begin
            dly_addr_s = rev_ext_s[SIZE-1:0];
        end else begin
            dly_addr_s = rd_ptr;
        end
    end

    assign addr_unused_s = ^{top_ext_s[FFT_MAX_W-1:SIZE], bot_ext_s[FFT_MAX_W-1:SIZE],
                             tw_ext_s[FFT_MAX_W-1:SIZE-1], rev_ext_s[FFT_MAX_W-1:SIZE]};

    fft_addr_delay #(
        .LAT  (LAT),
        .SIZE (SIZE)
    ) u_wr_delay (
        .clk    (clk),
        .rst    (rst),
        .vld_i  (en_rd),
        .addr_i (dly_addr_s),
        .vld_o  (en_wr),
        .addr_o (wr_ptr)
    );

endmodule

// File: tb/tb_fft_stage_addr_ctrl.sv
module tb_fft_stage_addr_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT A: N=16, LAT=3
    logic       start_a = 1'b0, brev_a = 1'b0;
    logic [3:0] stage_a = 4'd0;
    logic       busy_a, done_a, err_a, en_rd_a, tw_en_a, en_wr_a;
    logic [3:0] rd_a, wr_a;
    logic [2:0] tw_a;

    // DUT B: N=8, LAT=1
    logic       start_b = 1'b0, brev_b = 1'b0;
    logic [2:0] stage_b = 3'd0;
    logic       busy_b, done_b, err_b, en_rd_b, tw_en_b, en_wr_b;
    logic [2:0] rd_b, wr_b;
    logic [1:0] tw_b;

    fft_stage_addr_ctrl #(.N(16), .SIZE(4), .LAT(3)) dut (
        .clk(clk), .rst(rst), .start(start_a), .stage_i(stage_a), .brev_i(brev_a),
        .busy(busy_a), .done_o(done_a), .err_o(err_a), .en_rd(en_rd_a), .rd_ptr(rd_a),
        .en_rd_tw(tw_en_a), .tw_ptr(tw_a), .en_wr(en_wr_a), .wr_ptr(wr_a));

    fft_stage_addr_ctrl #(.N(8), .SIZE(3), .LAT(1)) dut8 (
        .clk(clk), .rst(rst), .start(start_b), .stage_i(stage_b), .brev_i(brev_b),
        .busy(busy_b), .done_o(done_b), .err_o(err_b), .en_rd(en_rd_b), .rd_ptr(rd_b),
        .en_rd_tw(tw_en_b), .tw_ptr(tw_b), .en_wr(en_wr_b), .wr_ptr(wr_b));

    int passed = 0;
    int total  = 0;
    int rd_cap [16];
    int tw_cap [16];
    int wr_cap [16];

    typedef struct {
        int s; bit br; int k; int exp_rd; int exp_tw; int exp_wr;
    } vec_t;
    vec_t tbl [21];

    // Output vector layout: {2'b0, busy, done, err, en_rd, rd[8], en_tw, tw[8], en_wr, wr[8]}
    function automatic logic [31:0] pack(int busy, int done, int err, int rden, int rd,
                                         int twen, int tw, int wren, int wr);
        logic [31:0] v;
        v = 32'd0;
        v[29] = (busy != 0);
        v[28] = (done != 0);
        v[27] = (err != 0);
        v[26] = (rden != 0);
        v[25:18] = rd[7:0];
        v[17] = (twen != 0);
        v[16:9] = tw[7:0];
        v[8] = (wren != 0);
        v[7:0] = wr[7:0];
        return v;
    endfunction

    function automatic logic [31:0] sample(int which);
        if (which == 0)
            return {2'b00, busy_a, done_a, err_a, en_rd_a, 4'b0000, rd_a, tw_en_a,
                    5'b00000, tw_a, en_wr_a, 4'b0000, wr_a};
        else
            return {2'b00, busy_b, done_b, err_b, en_rd_b, 5'b00000, rd_b, tw_en_b,
                    6'b000000, tw_b, en_wr_b, 5'b00000, wr_b};
    endfunction

    // Reference: k-th read address of stage s. Butterfly b pairs
    // (block*2h + offset, +h) with h = N/2 >> s.
    function automatic int read_addr(int n, int s, int k);
        int h, b, top;
        h = (n / 2) >> s;
        b = k / 2;
        top = (b / h) * 2 * h + (b % h);
        return top + (k % 2) * h;
    endfunction

    function automatic int rev_bits(int a, int n);
        int w, r;
        w = 0;
        while ((1 << w) < n) w++;
        r = 0;
        for (int i = 0; i < w; i++) r = r * 2 + ((a >> i) & 1);
        return r;
    endfunction

    // Expected outputs in cycle c (start sampled at cycle 0).
    function automatic logic [31:0] model_vec(int n, int lat, int s, bit br, int c);
        int busy, done, rden, rd, twen, tw, wren, wr, k, h, a;
        busy = (c >= 1 && c <= n + lat) ? 1 : 0;
        done = (c == n + lat + 1) ? 1 : 0;
        rden = 0; rd = 0; twen = 0; tw = 0; wren = 0; wr = 0;
        h = (n / 2) >> s;
        if (c >= 1 && c <= n) begin
            k = c - 1;
            rden = 1;
            rd = read_addr(n, s, k);
            if (k % 2 == 0) begin
                twen = 1;
                tw = (((k / 2) % h) << s) % (n / 2);
            end
        end
        if (c >= 1 + lat && c <= n + lat) begin
            wren = 1;
            a = read_addr(n, s, c - 1 - lat);
            wr = br ? rev_bits(a, n) : a;
        end
        return pack(busy, done, 0, rden, rd, twen, tw, wren, wr);
    endfunction

    task automatic check(input string name, input int c, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s c=%0d got=%h exp=%h", name, c, got, exp);
    endtask

    task automatic drive(input int which, input bit st, input int stg, input bit br);
        if (which == 0) begin
            start_a = st; stage_a = stg[3:0]; brev_a = br;
        end else begin
            start_b = st; stage_b = stg[2:0]; brev_b = br;
        end
    endtask

    // One pass on DUT 'which', compared cycle by cycle against the model.
    // noise: random start/stage/brev during the pass; mid_c: forced start at
    // that cycle; abort_at: assert rst in that cycle and stop.
    task automatic run_pass(input int which, input int s, input bit br, input bit noise,
                            input int mid_c, input int abort_at);
        int n, lat, smax;
        logic [31:0] got;
        n    = (which == 0) ? 16 : 8;
        lat  = (which == 0) ? 3 : 1;
        smax = (which == 0) ? 15 : 7;
        for (int i = 0; i < 16; i++) begin
            rd_cap[i] = -1; tw_cap[i] = -1; wr_cap[i] = -1;
        end
        drive(which, 1'b1, s, br);
        for (int c = 1; c <= n + lat + 2; c++) begin
            @(negedge clk);
            got = sample(which);
            check("pass", c, got, model_vec(n, lat, s, br, c));
            if (got[26]) rd_cap[c-1] = int'(got[25:18]);
            if (got[17]) tw_cap[c-1] = int'(got[16:9]);
            if (got[8] && (c - 1 - lat) >= 0 && (c - 1 - lat) < 16)
                wr_cap[c-1-lat] = int'(got[7:0]);
            if (c == abort_at) begin
                #1 rst = 1'b1;
                #1 check("rst_async", c, sample(which), 32'd0);
                drive(which, 1'b0, 0, 1'b0);
                break;
            end
            if (noise && c <= n + lat + 1)
                drive(which, ($urandom_range(0, 3) == 0), $urandom_range(0, smax),
                      1'($urandom_range(0, 1)));
            else
                drive(which, 1'b0, $urandom_range(0, smax), 1'($urandom_range(0, 1)));
            if (c == mid_c)
                drive(which, 1'b1, $urandom_range(0, smax), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic err_test(input int which, input int bad_stage);
        drive(which, 1'b1, bad_stage, 1'b0);
        @(negedge clk);
        check("err_pulse", 1, sample(which), pack(0, 0, 1, 0, 0, 0, 0, 0, 0));
        drive(which, 1'b0, 0, 1'b0);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            check("err_idle", c, sample(which), 32'd0);
        end
    endtask

    initial begin
        int last_cfg, cfg;
        tbl[0]  = '{0, 1'b0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1'b0, 1, 8, -1, 8};
        tbl[2]  = '{0, 1'b0, 2, 1, 1, 1};
        tbl[3]  = '{0, 1'b0, 14, 7, 7, 7};
        tbl[4]  = '{0, 1'b0, 15, 15, -1, 15};
        tbl[5]  = '{1, 1'b0, 8, 8, 0, 8};
        tbl[6]  = '{1, 1'b0, 9, 12, -1, 12};
        tbl[7]  = '{1, 1'b0, 10, 9, 2, 9};
        tbl[8]  = '{1, 1'b0, 11, 13, -1, 13};
        tbl[9]  = '{3, 1'b0, 0, 0, 0, 0};
        tbl[10] = '{3, 1'b0, 1, 1, -1, 1};
        tbl[11] = '{3, 1'b0, 6, 6, 0, 6};
        tbl[12] = '{3, 1'b0, 7, 7, -1, 7};
        tbl[13] = '{3, 1'b1, 0, 0, 0, 0};
        tbl[14] = '{3, 1'b1, 1, 1, -1, 8};
        tbl[15] = '{3, 1'b1, 2, 2, 0, 4};
        tbl[16] = '{3, 1'b1, 3, 3, -1, 12};
        tbl[17] = '{3, 1'b1, 4, 4, 0, 2};
        tbl[18] = '{3, 1'b1, 5, 5, -1, 10};
        tbl[19] = '{3, 1'b1, 8, 8, 0, 1};
        tbl[20] = '{3, 1'b1, 9, 9, -1, 9};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset_a", 0, sample(0), 32'd0);
        check("reset_b", 0, sample(1), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_a", 0, sample(0), 32'd0);

        // Table-driven spot checks of known sequences
        last_cfg = -1;
        for (int i = 0; i < 21; i++) begin
            cfg = tbl[i].s * 2 + int'(tbl[i].br);
            if (cfg != last_cfg) begin
                run_pass(0, tbl[i].s, tbl[i].br, 1'b0, 0, 0);
                last_cfg = cfg;
            end
            check("tbl_rd", i, rd_cap[tbl[i].k], tbl[i].exp_rd);
            if (tbl[i].exp_tw >= 0) check("tbl_tw", i, tw_cap[tbl[i].k], tbl[i].exp_tw);
            check("tbl_wr", i, wr_cap[tbl[i].k], tbl[i].exp_wr);
        end

        // Rejected starts
        err_test(0, 4);
        err_test(0, $urandom_range(5, 15));

        // Start pulse at cycle 5 is ignored
        run_pass(0, 2, 1'b0, 1'b0, 5, 0);

        // Randomized passes with start/stage/brev noise mid-pass
        for (int r = 0; r < 6; r++)
            run_pass(0, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1, 0, 0);

        // Reset at cycle 10 aborts the pass; nothing follows
        run_pass(0, 1, 1'b1, 1'b0, 0, 10);
        @(negedge clk);
        check("rst_hold", 0, sample(0), 32'd0);
        rst = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check("post_rst", c, sample(0), 32'd0);
        end
        run_pass(0, 2, 1'b1, 1'b0, 0, 0);

        // N=8, LAT=1: back-to-back passes, then brev with noise
        run_pass(1, 0, 1'b0, 1'b0, 0, 0);
        run_pass(1, 0, 1'b0, 1'b0, 0, 0);
        run_pass(1, 2, 1'b1, 1'b1, 0, 0);
        err_test(1, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
